// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-controller-side signal bundle for mem_arbiter.
// master = the arbiter's view, slave = the surrounding clients/controller.
interface mem_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned M_WIDTH = 8,
  parameter int unsigned M_DEPTH = 8192
);
  localparam int unsigned AW = $clog2(M_DEPTH);

  logic [N_REQ-1:0]         req;
  logic [2*N_REQ-1:0]       req_op;
  logic [N_REQ*AW-1:0]      req_addr;
  logic [N_REQ*M_WIDTH-1:0] req_din1;
  logic [N_REQ*M_WIDTH-1:0] req_din2;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         done;
  logic [M_WIDTH-1:0]       rd_data1;
  logic [M_WIDTH-1:0]       rd_data2;
  logic                     busy;
  logic                     err;
  logic [2:0]               mc_cmd;
  logic [AW-1:0]            mc_addr;
  logic [M_WIDTH-1:0]       mc_din1;
  logic [M_WIDTH-1:0]       mc_din2;
  logic [M_WIDTH-1:0]       mc_dout1;
  logic [M_WIDTH-1:0]       mc_dout2;
  logic                     mc_cplt;

  modport master (
    input  req, req_op, req_addr, req_din1, req_din2,
    input  mc_dout1, mc_dout2, mc_cplt,
    output gnt, done, rd_data1, rd_data2, busy, err,
    output mc_cmd, mc_addr, mc_din1, mc_din2
  );

  modport slave (
    output req, req_op, req_addr, req_din1, req_din2,
    output mc_dout1, mc_dout2, mc_cplt,
    input  gnt, done, rd_data1, rd_data2, busy, err,
    input  mc_cmd, mc_addr, mc_din1, mc_din2
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory controller between N_REQ clients.
// Optional watchdog abort of a stuck controller op: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned M_WIDTH = 8,
  parameter int unsigned M_DEPTH = 8192,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned AW = $clog2(M_DEPTH);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [M_WIDTH-1:0] rd1_q, rd1_d;
  logic [M_WIDTH-1:0] rd2_q, rd2_d;
  logic               busy_q, busy_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [M_WIDTH-1:0] din1_q, din1_d;
  logic [M_WIDTH-1:0] din2_q, din2_d;

  logic               found;
  logic [IW-1:0]      win;
  int unsigned        cand;
  logic [1:0]         win_op;
  logic [AW-1:0]      win_addr;
  logic [M_WIDTH-1:0] win_din1;
  logic [M_WIDTH-1:0] win_din2;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Rotating priority search: first request at or after last+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && bus.req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  // Winner's operands from the flattened request buses.
  always_comb begin
    win_op   = '0;
    win_addr = '0;
    win_din1 = '0;
    win_din2 = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) begin
        win_op   = bus.req_op[2*i +: 2];
        win_addr = bus.req_addr[AW*i +: AW];
        win_din1 = bus.req_din1[M_WIDTH*i +: M_WIDTH];
        win_din2 = bus.req_din2[M_WIDTH*i +: M_WIDTH];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    din1_d  = din1_q;
    din2_d  = din2_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_d = 3'b000;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (found) begin
          cmd_d      = {1'b1, win_op};
          addr_d     = win_addr;
          din1_d     = win_din1;
          din2_d     = win_din2;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          last_d     = win;
          state_d    = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (bus.mc_cplt) begin
          rd1_d          = bus.mc_dout1;
          rd2_d          = bus.mc_dout2;
          done_d[last_q] = 1'b1;
          cmd_d          = 3'b000;
          state_d        = S_RELEASE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Controller never answered: abort, keep the previous read data.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done_d[last_q] = 1'b1;
          err_d          = 1'b1;
          cmd_d          = 3'b000;
          state_d        = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      S_RELEASE: begin
        // Wait for the controller to drop its completion flag before re-arbitrating.
        if (!bus.mc_cplt) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        cmd_d   = 3'b000;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      busy_q  <= 1'b0;
      cmd_q   <= 3'b000;
      addr_q  <= '0;
      din1_q  <= '0;
      din2_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      busy_q  <= busy_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rd_data1 = rd1_q;
  assign bus.rd_data2 = rd2_q;
  assign bus.busy     = busy_q;
  assign bus.mc_cmd   = cmd_q;
  assign bus.mc_addr  = addr_q;
  assign bus.mc_din1  = din1_q;
  assign bus.mc_din2  = din2_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus hand sequences, with a controller model
// and a scoreboard of expected transactions checked on every done pulse.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned M_WIDTH = 8;
  localparam int unsigned M_DEPTH = 8192;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned AW      = $clog2(M_DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N_REQ(N_REQ), .M_WIDTH(M_WIDTH), .M_DEPTH(M_DEPTH)) bus ();

  mem_arbiter #(.N_REQ(N_REQ), .M_WIDTH(M_WIDTH), .M_DEPTH(M_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  typedef struct {
    int unsigned   who;
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [7:0]    d1;
    logic [7:0]    d2;
    logic          chk_rd;
    logic [7:0]    rd1;
    logic [7:0]    rd2;
    logic          err;
  } sb_t;

  typedef struct {
    int unsigned   who;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [7:0]    d1;
    logic [7:0]    d2;
    int unsigned   lat;
    logic [2:0]    exp_cmd;
    logic          chk_rd;
    logic [7:0]    exp_rd1;
    logic [7:0]    exp_rd2;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[6];

  // Controller model: completes after 'lat' active cycles; dout1=addr^4A, dout2=addr^B5.
  int unsigned lat   = 0;
  logic        stall = 1'b0;
  int unsigned mcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mc_cplt  <= 1'b0;
      bus.mc_dout1 <= '0;
      bus.mc_dout2 <= '0;
      mcnt         <= 0;
    end else begin
      bus.mc_cplt <= 1'b0;
      if (bus.mc_cmd[2] && !bus.mc_cplt && !stall) begin
        if (mcnt >= lat) begin
          bus.mc_cplt  <= 1'b1;
          bus.mc_dout1 <= bus.mc_addr[7:0] ^ 8'h4A;
          bus.mc_dout2 <= bus.mc_addr[7:0] ^ 8'hB5;
          mcnt         <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end else begin
        mcnt <= 0;
      end
    end
  end

  // Monitor: grant one-hot, command stability, scoreboard compare on done.
  logic          act_prev = 1'b0;
  logic [2:0]    s_cmd;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_d1, s_d2;
  logic          s_stable;
  sb_t           e;
  int            done_seen[N_REQ];

  always @(negedge clk) begin
    if (!rst) begin
      act_prev = 1'b0;
    end else begin
      check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      if (bus.mc_cmd[2]) begin
        if (!act_prev) begin
          s_cmd = bus.mc_cmd; s_addr = bus.mc_addr; s_d1 = bus.mc_din1; s_d2 = bus.mc_din2;
          s_stable = 1'b1;
        end else if (bus.mc_cmd != s_cmd || bus.mc_addr != s_addr ||
                     bus.mc_din1 != s_d1 || bus.mc_din2 != s_d2) begin
          s_stable = 1'b0;
        end
      end
      act_prev = bus.mc_cmd[2];
      for (int i = 0; i < int'(N_REQ); i++) if (bus.done[i]) done_seen[i]++;
      if (bus.done != '0) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_done",   32'(bus.done), 32'd1 << e.who);
          check("sb_gnt",    32'(bus.gnt),  32'd1 << e.who);
          check("sb_cmd",    32'(s_cmd),    32'(e.cmd));
          check("sb_addr",   32'(s_addr),   32'(e.addr));
          check("sb_din1",   32'(s_d1),     32'(e.d1));
          check("sb_din2",   32'(s_d2),     32'(e.d2));
          check("sb_stable", 32'(s_stable), 32'd1);
          check("sb_err",    32'(bus.err),  32'(e.err));
          if (e.chk_rd) begin
            check("sb_rd1", 32'(bus.rd_data1), 32'(e.rd1));
            check("sb_rd2", 32'(bus.rd_data2), 32'(e.rd2));
          end
        end
      end
    end
  end

  task automatic set_req(input int unsigned who, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [7:0] d1, input logic [7:0] d2);
    bus.req_op[2*who +: 2]     = op;
    bus.req_addr[AW*who +: AW] = addr;
    bus.req_din1[8*who +: 8]   = d1;
    bus.req_din2[8*who +: 8]   = d2;
  endtask

  task automatic wait_cplt_done(input int unsigned who);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.mc_cplt) seen = 1'b1;
    end
    if (!seen) begin
      fail("cplt_wait");
    end else begin
      @(negedge clk);
      check("done_latency", 32'(bus.done), 32'd1 << who);
      check("cmd_cleared",  32'(bus.mc_cmd), 32'd0);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int c = 0; c < 10 && !idle; c++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    if (!idle) fail("idle_wait");
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    sb_t it;
    lat   = v.lat;
    stall = 1'b0;
    set_req(v.who, v.op, v.addr, v.d1, v.d2);
    it = '{v.who, v.exp_cmd, v.addr, v.d1, v.d2, v.chk_rd, v.exp_rd1, v.exp_rd2, 1'b0};
    sb_q.push_back(it);
    bus.req[v.who] = 1'b1;
    @(negedge clk);
    check("vec_cmd_latency", 32'(bus.mc_cmd), 32'(v.exp_cmd));
    check("vec_gnt",         32'(bus.gnt),    32'd1 << v.who);
    check("vec_busy",        32'(bus.busy),   32'd1);
    // Scramble the requester's inputs: the latched command must not follow.
    set_req(v.who, ~v.op, ~v.addr, ~v.d1, ~v.d2);
    wait_cplt_done(v.who);
    bus.req[v.who] = 1'b0;
    wait_idle();
  endtask

  logic [7:0] rr_rd1[4];
  logic [7:0] rr_rd2[4];
  int         d0;
  sb_t        it;
  bit         got;

  initial begin
    bus.req = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_din1 = '0; bus.req_din2 = '0;
    for (int i = 0; i < int'(N_REQ); i++) done_seen[i] = 0;
    vecs[0] = '{0, 2'b00, 13'h0010, 8'h00, 8'h00, 0, 3'b100, 1'b1, 8'h5A, 8'hA5};
    vecs[1] = '{2, 2'b11, 13'h1FFF, 8'hAA, 8'h55, 3, 3'b111, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1, 2'b01, 13'h0123, 8'h00, 8'h00, 1, 3'b101, 1'b1, 8'h69, 8'h96};
    vecs[3] = '{3, 2'b10, 13'h0F00, 8'h3C, 8'hC3, 0, 3'b110, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{3, 2'b00, 13'h00FF, 8'h00, 8'h00, 2, 3'b100, 1'b1, 8'hB5, 8'h4A};
    vecs[5] = '{0, 2'b01, 13'h1000, 8'h00, 8'h00, 5, 3'b101, 1'b1, 8'h4A, 8'hB5};
    rr_rd1 = '{8'h4B, 8'h48, 8'h49, 8'h4E};
    rr_rd2 = '{8'hB4, 8'hB7, 8'hB6, 8'hB1};

    repeat (3) @(negedge clk);
    check("rst_gnt",     32'(bus.gnt),      32'd0);
    check("rst_done",    32'(bus.done),     32'd0);
    check("rst_rd1",     32'(bus.rd_data1), 32'd0);
    check("rst_rd2",     32'(bus.rd_data2), 32'd0);
    check("rst_busy",    32'(bus.busy),     32'd0);
    check("rst_err",     32'(bus.err),      32'd0);
    check("rst_mc_cmd",  32'(bus.mc_cmd),   32'd0);
    check("rst_mc_addr", 32'(bus.mc_addr),  32'd0);
    check("rst_mc_din1", 32'(bus.mc_din1),  32'd0);
    check("rst_mc_din2", 32'(bus.mc_din2),  32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cmd", 32'(bus.mc_cmd), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Requester 1 drops req mid-transaction; it still completes exactly once.
    lat = 4;
    set_req(1, 2'b00, 13'h0042, 8'h00, 8'h00);
    it = '{1, 3'b100, 13'h0042, 8'h00, 8'h00, 1'b1, 8'h08, 8'hF7, 1'b0};
    sb_q.push_back(it);
    d0 = done_seen[1];
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("drop_gnt", 32'(bus.gnt), 32'b0010);
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_cplt_done(1);
    wait_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("drop_no_regrant", 32'(bus.gnt), 32'd0);
    end
    check("drop_done_once", 32'(done_seen[1] - d0), 32'd1);

    // Asynchronous reset in the middle of an active transaction.
    stall = 1'b1;
    set_req(2, 2'b10, 13'h0AAA, 8'h11, 8'h22);
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("rstmid_gnt_before", 32'(bus.gnt), 32'b0100);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid_gnt",  32'(bus.gnt),    32'd0);
    check("rstmid_cmd",  32'(bus.mc_cmd), 32'd0);
    check("rstmid_done", 32'(bus.done),   32'd0);
    check("rstmid_busy", 32'(bus.busy),   32'd0);
    bus.req = '0;
    stall   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // All four requesting: strict rotation from requester 0 after reset.
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 2'b00, AW'(i + 1), 8'h00, 8'h00);
      it = '{i, 3'b100, AW'(i + 1), 8'h00, 8'h00, 1'b1, rr_rd1[i], rr_rd2[i], 1'b0};
      sb_q.push_back(it);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (bus.done != '0) got = 1'b1;
      end
      if (!got) begin
        fail("rr_done_wait");
      end else begin
        check("rr_order", 32'(bus.done), 32'd1 << k);
        bus.req[k] = 1'b0;
        @(negedge clk);
        check("rr_gap_gnt",  32'(bus.gnt),  32'd0);
        check("rr_gap_busy", 32'(bus.busy), 32'd0);
        if (k < 3) begin
          @(negedge clk);
          check("rr_regrant", 32'(bus.gnt), 32'd1 << (k + 1));
        end
      end
    end
    wait_idle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Controller never completes: watchdog abort with err, previous read data kept.
    stall = 1'b1;
    set_req(0, 2'b00, 13'h0050, 8'h00, 8'h00);
    it = '{0, 3'b100, 13'h0050, 8'h00, 8'h00, 1'b1, 8'h4E, 8'hB1, 1'b1};
    sb_q.push_back(it);
    bus.req[0] = 1'b1;
    @(negedge clk);
    check("to_gnt", 32'(bus.gnt), 32'b0001);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("to_not_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("to_done", 32'(bus.done),   32'b0001);
    check("to_err",  32'(bus.err),    32'd1);
    check("to_cmd",  32'(bus.mc_cmd), 32'd0);
    bus.req[0] = 1'b0;
    stall = 1'b0;
    wait_idle();
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter that shares one single-port memory controller between N_REQ requesters, e.g. the display refresh engine and the IoT command parser.
It latches the winning request and drives the controller's 3-bit command, address and write data. It holds the command until the controller raises its completion flag, then returns read data and a done pulse to the winner.
It sits between the client blocks and the memory controller, which talks to the on-chip RAM.

Parameters:
N_REQ, 4, number of requesters (2..8)
M_WIDTH, 8, memory word width in bits
M_DEPTH, 8192, memory depth in words; AW = $clog2(M_DEPTH)
TIMEOUT, 64, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester request level
req_op  in  2*N_REQ  per-requester op, slice i at [2i+1:2i]: 00 read1, 01 read2, 10 write1, 11 write2
req_addr  in  N_REQ*AW  per-requester base address
req_din1  in  N_REQ*M_WIDTH  per-requester first write word
req_din2  in  N_REQ*M_WIDTH  per-requester second write word
gnt  out  N_REQ  one-hot grant, high for the whole transaction
done  out  N_REQ  one-cycle completion pulse to the granted requester
rd_data1  out  M_WIDTH  first read word, valid when done is high and held afterwards
rd_data2  out  M_WIDTH  second read word, valid when done is high and held afterwards
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse coincident with done on watchdog abort
mc_cmd  out  3  controller command; {1, op} while active, 000 otherwise
mc_addr  out  AW  controller address
mc_din1  out  M_WIDTH  controller first write word
mc_din2  out  M_WIDTH  controller second write word
mc_dout1  in  M_WIDTH  controller first read word
mc_dout2  in  M_WIDTH  controller second read word
mc_cplt  in  1  controller operation-complete flag

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0. Round-robin pointer last=N_REQ-1, so requester 0 has top priority.
- All outputs are registered.
- IDLE: if req is nonzero, pick the first asserted index searching upward from last+1 with wrap modulo N_REQ.
  - On that edge: latch the winner's op, addr, din1 and din2 into mc_cmd={1,op}, mc_addr, mc_din1 and mc_din2.
  - Set gnt[idx]=1 and last=idx, then go to ACTIVE.
  - With no request, stay in IDLE with mc_cmd=000.
- ACTIVE: hold all mc_* outputs stable, whatever happens on req, op or data.
  - On the first cycle with mc_cplt=1: capture rd_data1<=mc_dout1 and rd_data2<=mc_dout2 (write ops capture as well; value don't-care).
  - On that same edge: pulse done[idx], set mc_cmd=000, go to RELEASE.
- RELEASE: gnt stays high.
  - When mc_cplt=0 (controller back to idle): clear gnt and go to IDLE. Re-arbitration starts on the following edge.
- Latency, req to mc_cmd active: 1 edge. mc_cplt high to done: 1 edge. Minimum gap between back-to-back grants: 2 edges after done.
- Requester protocol: hold req, op, addr and data stable from request until done. Deassert req in the cycle after done.
  - A req still high when IDLE samples it is treated as a new request.
- Dropping req during ACTIVE does not abort; the transaction completes and done is still pulsed.
- Simultaneous requests: strict rotation. With all requests held high, grants go 0,1,2,3,0,...
- Address wrap for two-word ops is handled by the controller. The arbiter passes addr unchanged.
- rst asserted mid-transaction: immediate return to IDLE, mc_cmd=000, no done pulse, pointer reset.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in ACTIVE. If mc_cplt has not been seen after TIMEOUT cycles:
  - pulse done[idx] and err together;
  - leave rd_data unchanged;
  - set mc_cmd=000 and go to RELEASE.
- Not defined: no counter; err is tied to 0; ACTIVE waits indefinitely.

Test Plan:
- Reset, then req=0001, op0=00, addr0=0x0010, controller model returns 0x5A -> mc_cmd=100 and mc_addr=0x0010 one edge after req; done[0] one edge after mc_cplt rises; rd_data1=0x5A.
- req=0100, op2=11, addr2=0x1FFF, din1=0xAA, din2=0x55 -> mc_cmd=111, mc_addr=0x1FFF, mc_din1=0xAA and mc_din2=0x55 held stable until mc_cplt; gnt=0100 throughout; busy=1.
- req=1111 held high, each requester dropping req after its done -> grant order 0,1,2,3 and never two gnt bits high at once.
- req[1] high, dropped to 0 mid-ACTIVE -> transaction still completes, done[1] pulses once, and the next IDLE does not regrant 1.
- rst driven low while in ACTIVE -> gnt=0, mc_cmd=000 and done=0 asynchronously. After release, req=1111 grants requester 0 first.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=64, controller model never raises mc_cplt -> done and err pulse 64 cycles after grant, followed by mc_cmd=000.
